// File: rtl/ascii_pkg.sv
// Shared ASCII byte constants and parser state encoding for the decimal parser.
package ascii_pkg;

   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_COMMA = 8'h2C;
   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;

   typedef enum logic [2:0] {IDLE, SIGN, DIGITS, SKIP, EMIT} state_t;

endpackage

// File: rtl/ascii_digit_dec.sv
// Combinational ASCII byte classifier; inverse of the digit-to-ASCII encoder.
module ascii_digit_dec
   import ascii_pkg::*;
(
   input  logic [7:0] data,
   output logic [3:0] digit,
   output logic       is_digit,
   output logic       is_term,
   output logic       is_minus
);

   // '0'..'9' sit at 0x30..0x39, so the low nibble is the digit value.
   assign digit    = data[3:0];
   assign is_digit = (data >= ASCII_ZERO) && (data <= ASCII_NINE);
   assign is_term  = (data == ASCII_CR) || (data == ASCII_LF) ||
                     (data == ASCII_COMMA) || (data == ASCII_SPACE);
   assign is_minus = (data == ASCII_MINUS);

endmodule

// File: rtl/ascii_dec_parser.sv
// Streaming ASCII decimal-to-binary parser with valid/ready byte input and result output.
// Define ASCII_SIGN_EN to accept a single leading '-' and produce two's complement results.
module ascii_dec_parser
   import ascii_pkg::*;
#(
   parameter int VAL_W      = 32,
   parameter int MAX_DIGITS = 10,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [VAL_W-1:0] out_value,
   output logic [CNT_W-1:0] out_ndigits,
   output logic             out_err
);

`ifdef ASCII_SIGN_EN
   localparam logic [VAL_W+3:0] LIMIT = {5'b0, {(VAL_W-1){1'b1}}};
`else
   localparam logic [VAL_W+3:0] LIMIT = {4'b0, {VAL_W{1'b1}}};
`endif

   state_t             state, state_nxt;
   logic [VAL_W-1:0]   acc, acc_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [VAL_W+3:0]   wide;
   logic [3:0]         digit;
   logic               is_digit, is_term, is_minus;
   logic               take, load, load_err;
`ifdef ASCII_SIGN_EN
   logic               neg, neg_nxt;
`endif

   // acc*10 + d at VAL_W+4 bits so any single-digit overflow is visible.
   function automatic logic [VAL_W+3:0] mac10(input logic [VAL_W-1:0] a, input logic [3:0] d);
      logic [VAL_W+3:0] aw;
      aw = {4'b0, a};
      return (aw << 3) + (aw << 1) + {{VAL_W{1'b0}}, d};
   endfunction

   ascii_digit_dec u_dec (
      .data     (in_data),
      .digit    (digit),
      .is_digit (is_digit),
      .is_term  (is_term),
      .is_minus (is_minus)
   );

   // Handshake flags come straight from the state register: no out_ready -> in_ready path.
   assign in_ready  = (state != EMIT);
   assign out_valid = (state == EMIT);
   assign take      = in_valid && in_ready;
   assign wide      = mac10(acc, digit);

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      load      = 1'b0;
      load_err  = 1'b0;
`ifdef ASCII_SIGN_EN
      neg_nxt   = neg;
`endif
      case (state)
         IDLE: if (take) begin
            if (is_digit) begin
               acc_nxt   = {{(VAL_W-4){1'b0}}, digit};
               cnt_nxt   = CNT_W'(1);
               state_nxt = DIGITS;
`ifdef ASCII_SIGN_EN
               neg_nxt   = 1'b0;
            end else if (is_minus) begin
               neg_nxt   = 1'b1;
               state_nxt = SIGN;
`endif
            end else if (!is_term) begin
               state_nxt = SKIP;
            end
         end
         SIGN: if (take) begin
            if (is_digit) begin
               acc_nxt   = {{(VAL_W-4){1'b0}}, digit};
               cnt_nxt   = CNT_W'(1);
               state_nxt = DIGITS;
            end else if (is_term) begin
               load_err  = 1'b1;
               state_nxt = EMIT;
            end else begin
               state_nxt = SKIP;
            end
         end
         DIGITS: if (take) begin
            if (is_digit) begin
               if ((wide > LIMIT) || (cnt == CNT_W'(MAX_DIGITS))) begin
                  state_nxt = SKIP;
               end else begin
                  acc_nxt = wide[VAL_W-1:0];
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end else if (is_term) begin
               load      = 1'b1;
               state_nxt = EMIT;
            end else begin
               state_nxt = SKIP;
            end
         end
         SKIP: if (take && is_term) begin
            load_err  = 1'b1;
            state_nxt = EMIT;
         end
         EMIT: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         out_value   <= '0;
         out_ndigits <= '0;
         out_err     <= 1'b0;
`ifdef ASCII_SIGN_EN
         neg         <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
`ifdef ASCII_SIGN_EN
         neg   <= neg_nxt;
`endif
         if (load) begin
`ifdef ASCII_SIGN_EN
            out_value <= neg ? -acc : acc;
`else
            out_value <= acc;
`endif
            out_ndigits <= cnt;
            out_err     <= 1'b0;
         end else if (load_err) begin
            out_value   <= '0;
            out_ndigits <= '0;
            out_err     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Scoreboard bench for ascii_dec_parser: expected results queued at stimulus, compared on output transfer.
module tb_ascii_dec_parser;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_value;
   logic [3:0]  out_ndigits;
   logic        out_err;

   typedef struct {
      logic [31:0] value;
      logic [3:0]  nd;
      logic        err;
   } res_t;

   res_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ascii_dec_parser dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_value   (out_value),
      .out_ndigits (out_ndigits),
      .out_err     (out_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] v, input logic [3:0] n, input logic e);
      res_t r;
      r.value = v;
      r.nd    = n;
      r.err   = e;
      sb.push_back(r);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int k;
      in_valid = 1'b1;
      in_data  = b;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (k == 100) check("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic wait_drain();
      int k;
      for (k = 0; k < 60; k++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0 && !out_valid) break;
      end
      if (k == 60) check("drain_timeout", 0, 1);
   endtask

   // Result monitor: a transfer happens at the posedge following this negedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            res_t e;
            e = sb.pop_front();
            check("value", out_value, e.value);
            check("ndigits", out_ndigits, e.nd);
            check("err", out_err, e.err);
         end
      end
   end

   initial begin
      logic [31:0] held_v;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_value", out_value, 0);
      check("rst_ndigits", out_ndigits, 0);
      check("rst_err", out_err, 0);

      // Basic number with latency check around the CR
      push(32'd123, 4'd3, 1'b0);
      send_str("123");
      check("pre_cr_out_valid", out_valid, 0);
      send_byte(8'h0D);
      check("latency_out_valid", out_valid, 1);
      check("latency_in_ready", in_ready, 0);
      wait_drain();

      // Blank separators produce nothing; leading zeros counted
      send_str("\015\012\015\012");
      check("blank_out_valid", out_valid, 0);
      check("blank_in_ready", in_ready, 1);
      push(32'd7, 4'd3, 1'b0);
      send_str("007,");
      wait_drain();

      // Range limits
`ifdef ASCII_SIGN_EN
      push(32'h7FFFFFFF, 4'd10, 1'b0);
      send_str("2147483647 ");
      push(32'd0, 4'd0, 1'b1);
      send_str("2147483648 ");
`else
      push(32'hFFFFFFFF, 4'd10, 1'b0);
      send_str("4294967295 ");
      push(32'd0, 4'd0, 1'b1);
      send_str("4294967296 ");
`endif
      wait_drain();

      // Digit count limit: 10 digits fine, 11 is an error
      push(32'd1, 4'd10, 1'b0);
      send_str("0000000001,");
      push(32'd0, 4'd0, 1'b1);
      send_str("00000000001,");
      wait_drain();

      // Illegal character, then recovery
      push(32'd0, 4'd0, 1'b1);
      push(32'd56, 4'd2, 1'b0);
      send_str("12a34,56\012");
      wait_drain();

      // Sign handling
`ifdef ASCII_SIGN_EN
      push(32'hFFFFFFD3, 4'd2, 1'b0);
      send_str("-45,");
      push(32'd0, 4'd0, 1'b1);
      send_str("-\015");
      push(32'd0, 4'd1, 1'b0);
      send_str("-0,");
      push(32'd0, 4'd0, 1'b1);
      send_str("4-5,");
`else
      push(32'd0, 4'd0, 1'b1);
      send_str("-45,");
      push(32'd0, 4'd0, 1'b1);
      send_str("-\015");
`endif
      wait_drain();

      // Backpressure: outputs must hold while out_ready is low
      out_ready = 1'b0;
      push(32'd9876, 4'd4, 1'b0);
      send_str("9876,");
      held_v = out_value;
      check("bp_first_value", held_v, 32'd9876);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out_valid", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
         check("bp_value_stable", out_value, held_v);
         check("bp_ndigits_stable", out_ndigits, 4);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_after_out_valid", out_valid, 0);
      check("bp_after_in_ready", in_ready, 1);
      wait_drain();

      // Reset mid-number discards the partial value
      send_str("12");
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      push(32'd7, 4'd1, 1'b0);
      send_str("7\015");
      wait_drain();

      // Reset during EMIT drops the pending result
      out_ready = 1'b0;
      send_str("55,");
      check("emit_pending", out_valid, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      check("emit_rst_out_valid", out_valid, 0);
      check("emit_rst_value", out_value, 0);
      repeat (3) @(posedge clk);
      #1;

      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule
